// File: rtl/regfile_2r1w_if.sv
// Request/response bundle for the 2-read/1-write register file.
// Requests (we, re_a, re_b) take effect at the edge they are sampled. They are
// accepted only while busy=0. There is no backpressure. A write that arrives
// while busy=1 is dropped and flagged with wr_drop in the following cycle.
interface regfile_2r1w_if #(
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 16
);
    localparam int BE_W = WIDTH / 8;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [BE_W-1:0]   wbe;
    logic              re_a;
    logic              re_b;
    logic [ADDR_W-1:0] raddr_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [WIDTH-1:0]  rdata_a;
    logic [WIDTH-1:0]  rdata_b;
    logic              rvalid_a;
    logic              rvalid_b;
    logic              busy;
    logic              wr_drop;

    modport master (
        output we, waddr, wdata, wbe, re_a, re_b, raddr_a, raddr_b,
        input  rdata_a, rdata_b, rvalid_a, rvalid_b, busy, wr_drop
    );

    modport slave (
        input  we, waddr, wdata, wbe, re_a, re_b, raddr_a, raddr_b,
        output rdata_a, rdata_b, rvalid_a, rvalid_b, busy, wr_drop
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Register file with two registered read ports, one byte-enabled write port,
// write-first forwarding and a post-reset clear sweep of one entry per cycle.
module regfile_2r1w #(
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 16
) (
    input  logic             clk,
    input  logic             reset,
    regfile_2r1w_if.slave    bus,
    output logic             fsm_state
);
    localparam int SIZE = 1 << ADDR_W;
    localparam int BE_W = WIDTH / 8;
    localparam logic [ADDR_W-1:0] LAST_ENTRY = {ADDR_W{1'b1}};

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [WIDTH-1:0]  mem [SIZE];
    logic [WIDTH-1:0]  fwd_a;
    logic [WIDTH-1:0]  fwd_b;

    assign fsm_state = state;

    // Post-write view of each read address. Only used in READY, so the sweep
    // can never leak into the read ports.
    always_comb begin
        fwd_a = mem[bus.raddr_a];
        fwd_b = mem[bus.raddr_b];
        if (bus.we) begin
            for (int k = 0; k < BE_W; k++) begin
                if (bus.wbe[k] && (bus.raddr_a == bus.waddr)) begin
                    fwd_a[8*k +: 8] = bus.wdata[8*k +: 8];
                end
                if (bus.wbe[k] && (bus.raddr_b == bus.waddr)) begin
                    fwd_b[8*k +: 8] = bus.wdata[8*k +: 8];
                end
            end
        end
    end

    // Storage has no reset; zeroing happens only through the sweep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (bus.we) begin
                for (int k = 0; k < BE_W; k++) begin
                    if (bus.wbe[k]) begin
                        mem[bus.waddr][8*k +: 8] <= bus.wdata[8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CLEAR;
            clr_ptr      <= '0;
            bus.busy     <= 1'b1;
            bus.rdata_a  <= '0;
            bus.rdata_b  <= '0;
            bus.rvalid_a <= 1'b0;
            bus.rvalid_b <= 1'b0;
            bus.wr_drop  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr      <= clr_ptr + 1'b1;
                    bus.wr_drop  <= bus.we;
                    bus.rvalid_a <= 1'b0;
                    bus.rvalid_b <= 1'b0;
                    if (clr_ptr == LAST_ENTRY) begin
                        state    <= READY;
                        bus.busy <= 1'b0;
                    end
                end
                READY: begin
                    bus.wr_drop  <= 1'b0;
                    bus.rvalid_a <= bus.re_a;
                    bus.rvalid_b <= bus.re_b;
                    if (bus.re_a) begin
                        bus.rdata_a <= fwd_a;
                    end
                    if (bus.re_b) begin
                        bus.rdata_b <= fwd_b;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end
endmodule
